// File: rtl/valid_ready_wb_bridge_pkg.sv
// Shared types and parameter checks for the valid/ready to Wishbone classic bridge.
package valid_ready_wb_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RWAIT,
    S_RESP
  } bridge_state_e;

  function automatic bit num_ports_ok(input int n);
    return (n == 1) || (n == 2);
  endfunction

  function automatic bit data_width_ok(input int w);
    return (w >= 8) && ((w % 8) == 0);
  endfunction

  // Counter only needs to reach TIMEOUT_CYCLES-1; keep at least one bit.
  function automatic int cnt_width(input int t);
    return (t < 3) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/valid_ready_wb_bridge_timeout.sv
// Wait-cycle counter: counts enabled cycles, flags the cycle that hits the limit.
module wb_timeout_counter
  import valid_ready_wb_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      // Fires on the enabled cycle that would bring the count to the limit.
      assign expired = enable && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                   cnt_d = '0;
    else if (enable && !expired) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/valid_ready_wb_bridge.sv
// Single-outstanding CPU valid/ready to Wishbone classic bridge, one or two master
// ports (split I/D), optional registered return stage and ack timeout.
module valid_ready_wb_bridge
  import valid_ready_wb_bridge_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_PORTS      = 1,
  parameter int REG_RESP       = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            sys_clk,
  input  logic                            rst_n,
  input  logic                            cpu_valid,
  input  logic                            cpu_instr,
  input  logic                            cpu_we,
  input  logic [ADDR_WIDTH-1:0]           cpu_addr,
  input  logic [DATA_WIDTH-1:0]           cpu_wdata,
  input  logic [DATA_WIDTH/8-1:0]         cpu_be,
  output logic [DATA_WIDTH-1:0]           cpu_rdata,
  output logic                            cpu_ready,
  output logic                            cpu_err,
  output logic [NUM_PORTS-1:0]            wb_cyc_o,
  output logic [NUM_PORTS-1:0]            wb_stb_o,
  output logic [NUM_PORTS-1:0]            wb_we_o,
  output logic [NUM_PORTS*DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [NUM_PORTS*ADDR_WIDTH-1:0] wb_adr_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] wb_dat_o,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wb_dat_i,
  input  logic [NUM_PORTS-1:0]            wb_ack_i
);

  localparam int BW = DATA_WIDTH / 8;

  generate
    if (!num_ports_ok(NUM_PORTS)) begin : g_bad_ports
      $error("valid_ready_wb_bridge: NUM_PORTS must be 1 or 2");
    end
    if (!data_width_ok(DATA_WIDTH)) begin : g_bad_width
      $error("valid_ready_wb_bridge: DATA_WIDTH must be a multiple of 8");
    end
  endgenerate

  bridge_state_e           state_q, state_d;
  logic                    we_q, we_d;
  logic                    port_q, port_d;
  logic                    err_q, err_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [BW-1:0]           be_q, be_d;
  logic [DATA_WIDTH-1:0]   cap_q, cap_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic                    in_bus, ack_sel, tmo;
  logic [DATA_WIDTH-1:0]   dat_sel, ret_data;

  assign in_bus = (state_q == S_BUS);

  // Only the target port's ack/data are ever looked at.
  always_comb begin
    ack_sel = 1'b0;
    dat_sel = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (int'(port_q) == p) begin
        ack_sel = wb_ack_i[p];
        dat_sel = wb_dat_i[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign ret_data = we_q ? '0 : dat_sel;

  wb_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .clear   (!in_bus),
    .enable  (in_bus && !ack_sel),
    .expired (tmo)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    port_d  = port_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    cap_d   = cap_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_valid) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          be_d    = cpu_be;
          port_d  = (NUM_PORTS == 2) ? !cpu_instr : 1'b0;
          err_d   = 1'b0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (ack_sel) begin
          err_d = 1'b0;
          if (REG_RESP != 0) begin
            cap_d   = ret_data;
            state_d = S_RWAIT;
          end else begin
            rdata_d = ret_data;
            state_d = S_RESP;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end
      end
      S_RWAIT: begin
        rdata_d = cap_q;
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      port_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      port_q  <= port_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
    end
  end

  assign cpu_ready = (state_q == S_RESP);
  assign cpu_err   = cpu_ready && err_q;
  assign cpu_rdata = rdata_q;

  // Bus outputs decode straight from state so reset clears them immediately.
  always_comb begin
    wb_cyc_o = '0;
    wb_stb_o = '0;
    wb_we_o  = '0;
    wb_sel_o = '0;
    wb_adr_o = '0;
    wb_dat_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (in_bus && (int'(port_q) == p)) begin
        wb_cyc_o[p]                          = 1'b1;
        wb_stb_o[p]                          = 1'b1;
        wb_we_o[p]                           = we_q;
        wb_sel_o[p*BW +: BW]                 = we_q ? be_q : '1;
        wb_adr_o[p*ADDR_WIDTH +: ADDR_WIDTH] = addr_q;
        wb_dat_o[p*DATA_WIDTH +: DATA_WIDTH] = wdata_q;
      end
    end
  end

endmodule

// File: doc/valid_ready_wb_bridge.md
VALID_READY_WB_BRIDGE -- requirements
Module: valid_ready_wb_bridge

Interface
REQ-001 Parameter DATA_WIDTH, default 32: CPU and Wishbone data width; multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 32: address width.
REQ-003 Parameter NUM_PORTS, default 1: Wishbone master ports; legal values 1 or 2 (2 = split instruction/data memory).
REQ-004 Parameter REG_RESP, default 0: 1 adds one register stage on ack/data return (pipelined-Wishbone mode).
REQ-005 Parameter TIMEOUT_CYCLES, default 1024: maximum cycles waiting for ack; 0 disables timeout.
REQ-006 sys_clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-008 cpu_valid  in  1  CPU request valid; held high until cpu_ready.
REQ-009 cpu_instr  in  1  1 = instruction fetch, 0 = data access.
REQ-010 cpu_we  in  1  1 = write, 0 = read.
REQ-011 cpu_addr  in  ADDR_WIDTH  request address.
REQ-012 cpu_wdata  in  DATA_WIDTH  write data.
REQ-013 cpu_be  in  DATA_WIDTH/8  write byte enables.
REQ-014 cpu_rdata  out  DATA_WIDTH  read data, valid while cpu_ready=1.
REQ-015 cpu_ready  out  1  one-cycle completion pulse.
REQ-016 cpu_err  out  1  qualifies cpu_ready; 1 = timeout.
REQ-017 wb_cyc_o, wb_stb_o, wb_we_o  out  NUM_PORTS each  per-port Wishbone classic controls.
REQ-018 wb_sel_o  out  NUM_PORTS*DATA_WIDTH/8;  wb_adr_o  out  NUM_PORTS*ADDR_WIDTH;  wb_dat_o  out  NUM_PORTS*DATA_WIDTH.
REQ-019 wb_dat_i  in  NUM_PORTS*DATA_WIDTH;  wb_ack_i  in  NUM_PORTS  per-port read data and ack.

Function
REQ-020 FSM states IDLE, BUS, RESP (+ RWAIT when REG_RESP=1); one transaction outstanding at a time.
REQ-021 IDLE: cpu_valid=1 latches instr/we/addr/wdata/be and target port, next state BUS; request inputs ignored until return to IDLE.
REQ-022 Target port = 0 when NUM_PORTS=1; when NUM_PORTS=2, port 0 for cpu_instr=1, port 1 for cpu_instr=0.
REQ-023 BUS: target port drives cyc=stb=1, we/adr/dat_o from latch; sel = latched be on write, all ones on read; non-target port all zeros.
REQ-024 BUS + target ack=1: cyc/stb drop next cycle; read data captured; next state RESP (REG_RESP=0) or RWAIT (REG_RESP=1, one extra cycle).
REQ-025 Latency: cpu_valid at cycle 0, cyc/stb from cycle 1, ack at cycle N, cpu_ready at N+1 (N+2 with REG_RESP=1).
REQ-026 RESP: cpu_ready=1 exactly one cycle, cpu_rdata = captured data (0 on write), cpu_err=0; next state IDLE unconditionally (one bubble between back-to-back requests).
REQ-027 Wait counter clears on BUS entry, increments each BUS cycle without ack; reaching TIMEOUT_CYCLES drops cyc/stb, enters RESP with cpu_err=1, cpu_rdata=0.
REQ-028 Ack and timeout in same cycle: ack wins, cpu_err=0.
REQ-029 Acks outside BUS, or on the non-target port, are ignored.
REQ-030 cpu_rdata holds last value when cpu_ready=0.

Reset
REQ-031 rst_n low: FSM to IDLE, counter 0, all wb_*_o, cpu_ready, cpu_err, cpu_rdata 0 immediately (asynchronous).
REQ-032 Reset mid-transaction abandons it: no cpu_ready issued, bus released; late ack after deassertion ignored.

Structure
REQ-033 Shared package holds the FSM state enum and legal-value checks for NUM_PORTS/DATA_WIDTH.
REQ-034 Sub-module wb_timeout_counter (clear/enable/expired) is instantiated once; all else in one module.

Verification
REQ-035 Read, NUM_PORTS=1: addr 0x100, ack after 3 cycles, wb_dat_i 0xDEADBEEF -> cpu_ready one cycle with cpu_rdata 0xDEADBEEF, err 0.
REQ-036 Write be=4'b0011, data 0x12345678 -> wb_we=1, wb_sel=4'b0011, wb_dat_o 0x12345678; read -> wb_sel=4'b1111.
REQ-037 NUM_PORTS=2: fetch at 0x0 drives only port 0; data load at 0x2000 drives only port 1; ack on wrong port -> no completion.
REQ-038 TIMEOUT_CYCLES=8, ack never: cyc drops after 8 BUS cycles, cpu_ready=1 with cpu_err=1, rdata 0; ack in cycle 8 -> err 0.
REQ-039 REG_RESP=1 vs 0, ack at cycle 2 -> cpu_ready at cycle 4 vs 3.
REQ-040 rst_n low during BUS -> outputs 0 same cycle; post-reset stray ack ignored; next request completes normally.
